// File: rtl/fetch_if.sv
// fetch_if: fetch-unit bus grouping the imem req/ack port, the decode valid/ready port and branch redirects.
interface fetch_if #(parameter int ADDR_W = 32);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              fetch_fault;
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches words over req/ack and hands them to decode over valid/ready.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky fault and halt fetch.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic     clock,
    input logic     reset,
    fetch_if.master bus
);
`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;
`endif
    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, addr_n, ipc_n, tgt;
    logic [31:0]       instr_n;
    logic              req_n, valid_n, fault_n, redir, bad, take;
`ifdef FETCH_ALIGN_CHECK_EN
    assign redir = bus.redirect_valid & ~bus.fetch_fault;
    assign bad   = redir & |bus.redirect_pc[1:0];
    assign tgt   = bus.redirect_pc;
`else
    assign redir = bus.redirect_valid;
    assign bad   = 1'b0;
    assign tgt   = bus.redirect_pc & ~ADDR_W'(3);
`endif
    // a response is only delivered when no redirect arrives in the same cycle
    assign take = state == REQ && bus.imem_ack && !redir;
    always_ff @(posedge clock)
        state <= reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = REQ;
            REQ:     state_n = redir ? (bus.imem_ack ? REQ : DRAIN) : (bus.imem_ack ? HOLD : REQ);
            HOLD:    state_n = (redir | bus.instr_ready) ? REQ : HOLD;
            DRAIN:   state_n = bus.imem_ack ? REQ : DRAIN;
            default: state_n = state;
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        // an outstanding request still drains before the halt takes effect
        if ((bad | bus.fetch_fault) && state_n != DRAIN) state_n = HALT;
`endif
    end
    always_comb begin
        pc_n    = redir ? tgt : (take ? pc + ADDR_W'(4) : pc);
        req_n   = state_n == REQ || state_n == DRAIN;
        addr_n  = state_n == REQ ? pc_n : bus.imem_addr;
        valid_n = state_n == HOLD;
        instr_n = take ? bus.imem_rdata : bus.instr;
        ipc_n   = take ? pc : bus.instr_pc;
        fault_n = bus.fetch_fault | bad;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            pc              <= RESET_PC;
            bus.imem_req    <= 1'b0;
            bus.imem_addr   <= RESET_PC;
            bus.instr_valid <= 1'b0;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.fetch_fault <= 1'b0;
        end else begin
            pc              <= pc_n;
            bus.imem_req    <= req_n;
            bus.imem_addr   <= addr_n;
            bus.instr_valid <= valid_n;
            bus.instr       <= instr_n;
            bus.instr_pc    <= ipc_n;
            bus.fetch_fault <= fault_n;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random fetch traffic against a flag-based reference model.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0;
    logic clock = 1'b0;
    logic reset;
    fetch_if #(.ADDR_W(32)) bus();
    fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    logic [31:0] m_pc, m_addr, m_instr, m_ipc, s_instr, s_pc;
    logic        m_req, m_valid, m_disc;
    int          mcnt = -1, mlat = 0, lat_fix = 0;
    int          checks = 0, errors = 0, n;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req", 32'(bus.imem_req), 32'(m_req));
        chk("imem_addr", bus.imem_addr, m_addr);
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        chk("instr", bus.instr, m_instr);
        chk("instr_pc", bus.instr_pc, m_ipc);
        chk("fetch_fault", 32'(bus.fetch_fault), 32'd0);
    endtask

    // The model tracks "holding an instruction", "request outstanding" and "response to discard".
    task automatic cycle();
        logic [31:0] tgt;
        if (bus.imem_req && !reset) begin
            if (mcnt < 0) begin
                mlat = lat_fix >= 0 ? lat_fix : int'($urandom_range(0, 3));
                mcnt = 0;
            end
            bus.imem_ack = mcnt == mlat;
        end else bus.imem_ack = 1'b0;
        bus.imem_rdata = bus.imem_ack ? mem(bus.imem_addr) : $urandom;
        @(posedge clock);
        tgt = bus.redirect_pc & ~32'd3;
        if (reset) begin
            m_pc = RST_PC; m_req = 0; m_addr = RST_PC; m_valid = 0;
            m_instr = 0; m_ipc = 0; m_disc = 0;
        end else if (m_valid) begin
            if (bus.redirect_valid) begin
                m_valid = 0; m_pc = tgt; m_req = 1; m_addr = tgt;
            end else if (bus.instr_ready) begin
                m_valid = 0; m_req = 1; m_addr = m_pc;
            end
        end else if (m_req) begin
            if (bus.imem_ack) begin
                if (m_disc || bus.redirect_valid) begin
                    if (bus.redirect_valid) m_pc = tgt;
                    m_disc = 0; m_addr = m_pc;
                end else begin
                    m_instr = bus.imem_rdata; m_ipc = m_pc; m_valid = 1;
                    m_pc = m_pc + 32'd4; m_req = 0;
                end
            end else if (bus.redirect_valid) begin
                m_pc = tgt; m_disc = 1;
            end
        end else begin
            if (bus.redirect_valid) m_pc = tgt;
            m_req = 1; m_addr = m_pc;
        end
        if (reset || bus.imem_ack) mcnt = -1;
        else if (mcnt >= 0) mcnt++;
        #1;
        check_all();
    endtask

    initial begin
        reset = 1; bus.instr_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
        bus.imem_ack = 0; bus.imem_rdata = 0;
        cycle(); cycle();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", bus.imem_addr, RST_PC);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        // zero-wait memory, decode always ready
        reset = 0; bus.instr_ready = 1; n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (bus.instr_valid) begin
                chk("seq_pc", bus.instr_pc, 32'(n * 4));
                chk("seq_instr", bus.instr, mem(32'(n * 4)));
                n++;
            end
        end
        chk("throughput", 32'(n), 32'd6);
        // slow memory and a decode stall
        lat_fix = 3; bus.instr_ready = 0;
        for (int i = 0; i < 20 && !m_valid; i++) cycle();
        chk("hold_reached", 32'(m_valid), 32'd1);
        s_instr = bus.instr; s_pc = bus.instr_pc;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_instr", bus.instr, s_instr);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
        end
        bus.instr_ready = 1;
        cycle();
        chk("next_addr", bus.imem_addr, s_pc + 32'd4);
        // redirect two cycles before the ack
        for (int i = 0; i < 20 && !(m_req && !m_disc && mcnt >= 0 && mlat - mcnt == 2); i++) cycle();
        bus.redirect_valid = 1; bus.redirect_pc = 32'h100;
        cycle();
        bus.redirect_valid = 0;
        for (int i = 0; i < 20 && !m_valid; i++) cycle();
        chk("redir100_pc", bus.instr_pc, 32'h100);
        // redirect coincident with ack, then two redirects while draining
        lat_fix = 2;
        for (int i = 0; i < 20 && !(m_req && !m_valid && !m_disc && mcnt >= 0 && mcnt == mlat); i++) cycle();
        bus.redirect_valid = 1; bus.redirect_pc = 32'h40;
        cycle();
        bus.redirect_valid = 0;
        chk("coinc_novalid", 32'(bus.instr_valid), 32'd0);
        chk("coinc_addr", bus.imem_addr, 32'h40);
        lat_fix = 3;
        cycle();
        bus.redirect_valid = 1; bus.redirect_pc = 32'h60;
        cycle();
        bus.redirect_pc = 32'h80;
        cycle();
        bus.redirect_valid = 0;
        for (int i = 0; i < 20 && !m_valid; i++) begin
            cycle();
            if (!m_valid) chk("drain_novalid", 32'(bus.instr_valid), 32'd0);
        end
        chk("redir80_pc", bus.instr_pc, 32'h80);
        // PC wrap at the top of the address space
        lat_fix = 0;
        bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFF_FFFC;
        cycle();
        bus.redirect_valid = 0;
        for (int i = 0; i < 20 && !(m_valid && m_ipc == 32'hFFFF_FFFC); i++) cycle();
        chk("wrap_pc", bus.instr_pc, 32'hFFFF_FFFC);
        cycle();
        for (int i = 0; i < 20 && !m_valid; i++) cycle();
        chk("wrap_next", bus.instr_pc, 32'h0);
        // misaligned target is truncated to a word
        bus.instr_ready = 0;
        for (int i = 0; i < 20 && !m_valid; i++) cycle();
        bus.redirect_valid = 1; bus.redirect_pc = 32'h102;
        cycle();
        bus.redirect_valid = 0;
        chk("mis_addr", bus.imem_addr, 32'h100);
        chk("mis_req", 32'(bus.imem_req), 32'd1);
        chk("mis_fault", 32'(bus.fetch_fault), 32'd0);
        // reset while a request is outstanding
        bus.instr_ready = 1; lat_fix = 3;
        for (int i = 0; i < 20 && !(m_req && mcnt >= 0); i++) cycle();
        reset = 1;
        cycle();
        reset = 0;
        chk("rreq_req", 32'(bus.imem_req), 32'd0);
        chk("rreq_valid", 32'(bus.instr_valid), 32'd0);
        cycle();
        chk("restart_addr", bus.imem_addr, RST_PC);
        chk("restart_req", 32'(bus.imem_req), 32'd1);
        // random traffic
        lat_fix = -1;
        for (int i = 0; i < 800; i++) begin
            reset = $urandom_range(0, 99) == 0;
            bus.instr_ready = $urandom_range(0, 9) < 7;
            bus.redirect_valid = $urandom_range(0, 9) == 0;
            bus.redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h3FF);
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
